osnt_bram_replay: RTL and testbench

// Replay engine that sits directly downstream of the OSNT packet BRAM. It reads stored 736-bit words
// (TDATA+TUSER+TKEEP+TLAST+word-valid) over the BRAM read port and regenerates them as an AXI4-Stream.
// It honours tready backpressure despite the BRAM's 1-cycle read latency, loops over the loaded region
// a programmable number of times, and stops only on packet boundaries.

---
 rtl/osnt_bram_replay.sv | 148 ++++++++++++++
 tb/tb_osnt_bram_replay.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osnt_bram_replay.sv
// Replays words from the OSNT packet BRAM as an AXI4-Stream, looping over the loaded region.
// A 2-entry FIFO absorbs the 1-cycle BRAM read latency so tready backpressure never loses a word.
//   state | meaning
//   IDLE  | waiting for start; no reads, FIFO empty
//   RUN   | issuing reads over 0..last_addr, wrapping per pass
//   DRAIN | no new reads; emptying FIFO and in-flight read, then done
`timescale 1ns/1ps
module osnt_bram_replay #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 736,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 128,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     axis_aclk,
  input  logic                     axis_resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_WIDTH-1:0]    last_addr,
  input  logic [CNT_WIDTH-1:0]     replay_cnt,
  output logic [ADDR_WIDTH-1:0]    bram_addr,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [DATA_WIDTH-1:0]    bram_wrdata,
  input  logic [DATA_WIDTH-1:0]    bram_rddata,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     loops_done
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
  localparam int TUSER_LO   = TDATA_WIDTH;
  localparam int TKEEP_LO   = TDATA_WIDTH + TUSER_WIDTH;
  localparam int TLAST_BIT  = TKEEP_LO + KEEP_WIDTH;
  localparam int WVALID_BIT = TLAST_BIT + 1;
  localparam int FIFO_WIDTH = TLAST_BIT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr, last_q;
  logic [CNT_WIDTH-1:0]  cnt_q, loops_inc;
  logic                  stop_req, flush, rd_pend;
  logic [FIFO_WIDTH-1:0] fifo_mem [2];
  logic [FIFO_WIDTH-1:0] head;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;
  logic                  push, pop, room, issue, stop_end, wrap, pass_done;
  logic                  unused_rd;

  assign unused_rd = ^bram_rddata[DATA_WIDTH-1:WVALID_BIT+1];

  assign pop  = (fifo_cnt != 2'd0) && m_axis_tready;
  assign push = rd_pend && bram_rddata[WVALID_BIT] && !(state == DRAIN && flush);
  assign stop_end = push && bram_rddata[TLAST_BIT] && stop_req && (state == RUN);

  // Counting this cycle's pop keeps 1 word/cycle while still guaranteeing room on return.
  assign occ   = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);
  assign room  = occ < 3'd2;
  assign issue = (state == RUN) && room && !stop_end;

  assign wrap      = (addr == last_q);
  assign loops_inc = (&loops_done) ? loops_done : loops_done + CNT_WIDTH'(1);
  assign pass_done = issue && wrap && (cnt_q != '0) && (loops_inc == cnt_q);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop_end || pass_done) state_nxt = DRAIN;
      DRAIN:   if (fifo_cnt == 2'd0 && !rd_pend) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      addr       <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      loops_done <= '0;
      stop_req   <= 1'b0;
      flush      <= 1'b0;
      rd_pend    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= (state == DRAIN) && (state_nxt == IDLE);
      rd_pend <= issue;
      if (state == IDLE && start) begin
        addr       <= '0;
        loops_done <= '0;
        last_q     <= last_addr;
        cnt_q      <= replay_cnt;
        stop_req   <= 1'b0;
        flush      <= 1'b0;
      end else begin
        if (stop && state != IDLE) stop_req <= 1'b1;
        if (stop_end) flush <= 1'b1;
        if (issue) begin
          addr <= wrap ? '0 : addr + ADDR_WIDTH'(1);
          if (wrap) loops_done <= loops_inc;
        end
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (push) fifo_mem[wr_ptr] <= bram_rddata[FIFO_WIDTH-1:0];
  end

  assign head          = fifo_mem[rd_ptr];
  assign m_axis_tdata  = head[TDATA_WIDTH-1:0];
  assign m_axis_tuser  = head[TKEEP_LO-1:TUSER_LO];
  assign m_axis_tkeep  = head[TLAST_BIT-1:TKEEP_LO];
  assign m_axis_tlast  = head[TLAST_BIT];
  assign m_axis_tvalid = (fifo_cnt != 2'd0);

  assign bram_addr   = addr;
  assign bram_en     = issue;
  assign bram_we     = 1'b0;
  assign bram_wrdata = '0;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_osnt_bram_replay.sv
// Scoreboard bench for osnt_bram_replay: directed replays against a behavioural BRAM,
// expected beats queued at stimulus time and checked by a separate monitor process.
`timescale 1ns/1ps
module tb_osnt_bram_replay;

  localparam int AW = 11;
  localparam int DW = 736;
  localparam int TW = 512;
  localparam int UW = 128;
  localparam int CW = 32;
  localparam int KW = TW / 8;

  logic          axis_aclk = 1'b0;
  logic          axis_resetn;
  logic          start, stop;
  logic [AW-1:0] last_addr;
  logic [CW-1:0] replay_cnt;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_we;
  logic [DW-1:0] bram_wrdata;
  logic [DW-1:0] bram_rddata = '0;
  logic [TW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          busy, done;
  logic [CW-1:0] loops_done;

  always #5 axis_aclk = ~axis_aclk;

  osnt_bram_replay dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .start(start), .stop(stop), .last_addr(last_addr), .replay_cnt(replay_cnt),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .loops_done(loops_done)
  );

  typedef struct packed {
    logic          tlast;
    logic [KW-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic [TW-1:0] tdata;
  } beat_t;

  function automatic beat_t mk_beat(int a, bit last);
    beat_t b;
    b.tdata = {16{32'hC0DE_0000 + 32'(a)}};
    b.tuser = {4{32'h5EE0_0000 + 32'(a)}};
    b.tkeep = last ? {{(KW-40){1'b0}}, {40{1'b1}}} : {KW{1'b1}};
    b.tlast = last;
    return b;
  endfunction

  // Unused upper bits filled with ones so any leakage shows up in the data
  function automatic logic [DW-1:0] mk_word(int a, bit last, bit wv);
    return {{(DW-706){1'b1}}, wv, mk_beat(a, last)};
  endfunction

  logic [DW-1:0] mem [16];
  always @(posedge axis_aclk) if (bram_en) bram_rddata <= mem[bram_addr[3:0]];

  int cyc = 0;
  always @(posedge axis_aclk) cyc <= cyc + 1;

  beat_t exp_q[$];
  beat_t held;
  int    checks = 0, errors = 0, beats = 0;
  int    span_mark = -1, first_cyc = 0, last_cyc = 0;
  bit    sb_en = 1'b1, prev_stall = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    beat_t c, e;
    c = {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
    if (!axis_resetn) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      checks++;
      if (!m_axis_tvalid || c !== held) begin
        errors++;
        $display("FAIL stall_hold: got tvalid=%0b tdata=%h tlast=%0b expected tvalid=1 tdata=%h tlast=%0b",
                 m_axis_tvalid, c.tdata[31:0], c.tlast, held.tdata[31:0], held.tlast);
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (beats == span_mark) first_cyc = cyc;
      beats++;
      last_cyc = cyc;
      if (sb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got tdata=%h tlast=%0b expected no beat", c.tdata[31:0], c.tlast);
        end else begin
          e = exp_q.pop_front();
          if (c !== e) begin
            errors++;
            $display("FAIL beat_data: got tdata=%h tuser=%h tkeep=%h tlast=%0b expected tdata=%h tuser=%h tkeep=%h tlast=%0b",
                     c.tdata[31:0], c.tuser[31:0], c.tkeep, c.tlast,
                     e.tdata[31:0], e.tuser[31:0], e.tkeep, e.tlast);
          end
        end
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    held = c;
  endtask

  task automatic do_start(int la, int cnt, bit with_stop);
    @(posedge axis_aclk); #1;
    last_addr  = AW'(la);
    replay_cnt = CW'(cnt);
    start = 1'b1;
    stop  = with_stop;
    @(posedge axis_aclk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(string name, bit rnd, int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge axis_aclk); #1;
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge axis_aclk);
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge axis_aclk);
    chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
    m_axis_tready = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic load_one_pkt4();
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = mk_word(i, i == 3, 1'b1);
  endtask

  task automatic run_tests();
    int b0;
    bit found;
    axis_resetn = 1'b0;
    start = 1'b0; stop = 1'b0; last_addr = '0; replay_cnt = '0; m_axis_tready = 1'b1;
    clear_mem();
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_loops", 64'(loops_done), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("bram_we_zero", 64'(bram_we), 64'd0);
    chk("bram_wrdata_zero", 64'(bram_wrdata == '0), 64'd1);
    repeat (3) @(negedge axis_aclk);
    axis_resetn = 1'b1;

    // Stop in IDLE is ignored
    @(posedge axis_aclk); #1; stop = 1'b1;
    @(posedge axis_aclk); #1; stop = 1'b0;
    @(negedge axis_aclk);
    chk("idle_stop_busy", 64'(busy), 64'd0);

    // 1: two passes, tready high, back-to-back
    load_one_pkt4();
    for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) exp_q.push_back(mk_beat(i, i == 3));
    b0 = beats; span_mark = beats;
    do_start(3, 2, 1'b0);
    wait_done("t1", 1'b0, 200);
    chk("t1_loops", 64'(loops_done), 64'd2);
    chk("t1_beats", 64'(beats - b0), 64'd8);
    chk("t1_back_to_back", 64'(last_cyc - first_cyc), 64'd7);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // 2: same load under random backpressure
    for (int p = 0; p < 2; p++) for (int i = 0; i < 4; i++) exp_q.push_back(mk_beat(i, i == 3));
    b0 = beats;
    do_start(3, 2, 1'b0);
    wait_done("t2", 1'b1, 400);
    chk("t2_loops", 64'(loops_done), 64'd2);
    chk("t2_beats", 64'(beats - b0), 64'd8);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // 3: infinite mode, stop while first beat of pkt 2 is presented
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = mk_word(i, i == 2 || i == 5, 1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk_beat(i, i == 2 || i == 5));
    b0 = beats;
    do_start(5, 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid && m_axis_tdata[31:0] == 32'hC0DE_0003) found = 1'b1;
    end
    chk("t3_pkt2_seen", 64'(found), 64'd1);
    stop = 1'b1;
    @(posedge axis_aclk); #1; stop = 1'b0;
    wait_done("t3", 1'b0, 100);
    chk("t3_loops", 64'(loops_done), 64'd1);
    chk("t3_beats", 64'(beats - b0), 64'd6);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: word-valid=0 at addr 1 is dropped
    clear_mem();
    mem[0] = mk_word(0, 1'b0, 1'b1);
    mem[1] = mk_word(1, 1'b0, 1'b0);
    mem[2] = mk_word(2, 1'b1, 1'b1);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(mk_beat(0, 1'b0));
      exp_q.push_back(mk_beat(2, 1'b1));
    end
    b0 = beats;
    do_start(2, 2, 1'b0);
    wait_done("t4", 1'b0, 100);
    chk("t4_loops", 64'(loops_done), 64'd2);
    chk("t4_beats", 64'(beats - b0), 64'd4);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: last_addr=0, 5 passes; stop in the start cycle must be ignored
    clear_mem();
    mem[0] = mk_word(0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk_beat(0, 1'b1));
    b0 = beats;
    do_start(0, 5, 1'b1);
    wait_done("t5", 1'b0, 100);
    chk("t5_loops", 64'(loops_done), 64'd5);
    chk("t5_beats", 64'(beats - b0), 64'd5);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset mid-replay while stalled with tvalid high
    load_one_pkt4();
    sb_en = 1'b0;
    do_start(3, 0, 1'b0);
    repeat (12) @(posedge axis_aclk);
    #1 m_axis_tready = 1'b0;
    repeat (4) @(posedge axis_aclk);
    @(negedge axis_aclk);
    chk("t6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    chk("t6_pre_loops_nonzero", 64'(loops_done != '0), 64'd1);
    #2 axis_resetn = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_loops", 64'(loops_done), 64'd0);
    chk("t6_rst_bram_en", 64'(bram_en), 64'd0);
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge axis_aclk);
    chk("t6_post_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_post_busy", 64'(busy), 64'd0);
    sb_en = 1'b1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge axis_aclk);
          monitor_step();
        end
      end
      begin
        run_tests();
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
